// File: rtl/uart_tx_fifo_drain_pkg.sv
// rtl/uart_tx_fifo_drain_pkg.sv - shared UART state encoding and parity-type constants
package uart_tx_fifo_drain_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// rtl/uart_tx_parity_calc.sv - even/odd parity bit for one UART data word
module uart_tx_parity_calc
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Even parity makes the total count of ones even; odd parity inverts that bit.
    always_comb begin
        par_bit = (^data) ^ (par_typ == PAR_ODD);
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - FIFO-draining UART transmitter, one bit per R_CLK
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  EMPTY,
    input  logic                  TX_EN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  RINC,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_reg;
    logic                  par_en_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_new;
    logic                  last_bit;

    // Parity is computed on the word as it is popped, so later PAR_TYP changes cannot touch it.
    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (RD_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_new)
    );

    // Pops only at frame boundaries; gated by reset so nothing is popped while held in reset.
    assign RINC     = R_RST & TX_EN & ~EMPTY & ((state == IDLE) | (state == STOP));
    assign BUSY     = (state != IDLE);
    assign last_bit = (bit_cnt == LAST_BIT);

    // State register.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: STOP chains straight into START when another word is available.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (RINC) state_nxt = START;
            START:   state_nxt = DATA;
            DATA:    if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = RINC ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on pop, then shift data out LSB first into the registered line.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            shift_reg <= '0;
            par_reg   <= 1'b0;
            par_en_q  <= 1'b0;
            bit_cnt   <= '0;
            TX_OUT    <= 1'b1;
        end else if (RINC) begin
            shift_reg <= RD_DATA;
            par_reg   <= par_new;
            par_en_q  <= PAR_EN;
            TX_OUT    <= 1'b0;
        end else begin
            case (state)
                START: begin
                    TX_OUT    <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= '0;
                end
                DATA: begin
                    if (last_bit) begin
                        TX_OUT <= par_en_q ? par_reg : 1'b1;
                    end else begin
                        TX_OUT    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    TX_OUT <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - self-checking bench for uart_tx_fifo_drain
module tb_uart_tx_fifo_drain;

    localparam int DW = 8;

    logic          R_CLK = 1'b0;
    logic          R_RST = 1'b0;
    logic [DW-1:0] RD_DATA;
    logic          EMPTY;
    logic          TX_EN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          RINC;
    logic          TX_OUT;
    logic          BUSY;

    uart_tx_fifo_drain #(.DATA_WIDTH(DW)) dut (
        .R_CLK   (R_CLK),
        .R_RST   (R_RST),
        .RD_DATA (RD_DATA),
        .EMPTY   (EMPTY),
        .TX_EN   (TX_EN),
        .PAR_EN  (PAR_EN),
        .PAR_TYP (PAR_TYP),
        .RINC    (RINC),
        .TX_OUT  (TX_OUT),
        .BUSY    (BUSY)
    );

    always #5 R_CLK = ~R_CLK;

    typedef struct {
        logic [DW-1:0] word;
        logic          pe;
        logic          pt;
    } frame_t;

    typedef struct {
        logic [7:0]  word;
        logic        pe;
        logic        pt;
        logic        toggle;
        logic [10:0] exp_bits;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fifo_q[$];
    frame_t        pops[$];
    logic          line_log[$];
    int            busy_cycles = 0;
    int            rinc_count = 0;
    int            bad_pop = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic sync_fifo();
        EMPTY   = (fifo_q.size() == 0);
        RD_DATA = EMPTY ? DW'($urandom) : fifo_q[0];
    endtask

    task automatic clear_logs();
        line_log.delete();
        rinc_count  = 0;
        busy_cycles = 0;
    endtask

    // One bit period: sample pop request before the edge, apply FIFO pop after it, log the line.
    task automatic step();
        logic   pf;
        frame_t fr;
        #1;
        pf      = RINC;
        fr.word = RD_DATA;
        fr.pe   = PAR_EN;
        fr.pt   = PAR_TYP;
        if (pf && (EMPTY || !TX_EN)) bad_pop++;
        @(posedge R_CLK);
        #1;
        if (pf && fifo_q.size() > 0) begin
            fifo_q.delete(0);
            pops.push_back(fr);
            rinc_count++;
        end
        sync_fifo();
        line_log.push_back(TX_OUT);
        if (BUSY) busy_cycles++;
    endtask

    // Reference frame: start 0, data LSB first, optional parity (even = xor of data), stop 1.
    function automatic logic [31:0] frame_bits(input logic [DW-1:0] w, input logic pe, input logic pt);
        logic [31:0] f;
        f = '0;
        for (int b = 0; b < DW; b++) f[1+b] = w[b];
        if (pe) begin
            f[DW+1] = (^w) ^ pt;
            f[DW+2] = 1'b1;
        end else begin
            f[DW+1] = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [31:0] log_slice(input int s, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++)
            if (s + k < line_log.size()) r[k] = line_log[s+k];
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        int          bad;
        int          n;
        int          pushed;
        int          guard;
        int          idx;
        int          nf;
        int          bad_fr;
        int          exp_busy;
        int          len;
        frame_t      fr;
        logic [31:0] exp3;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 11'h34A};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 11'h406};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b0, 11'h606};
        vecs[3] = '{8'h03, 1'b1, 1'b0, 1'b1, 11'h406};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11'h5FE};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 11'h600};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b0, 11'h300};

        // Reset held with a word waiting.
        TX_EN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        fifo_q.push_back(8'hC3);
        sync_fifo();
        bad = 0;
        repeat (5) begin
            @(posedge R_CLK); #1;
            if (TX_OUT !== 1'b1 || RINC !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        check("reset_hold", bad, 0);
        check("reset_tx_out", TX_OUT, 1);
        check("reset_busy", BUSY, 0);
        check("reset_rinc", RINC, 0);
        R_RST = 1'b1;
        #1;
        check("rinc_after_release", RINC, 1);
        clear_logs();
        step();
        check("start_bit_after_release", TX_OUT, 0);
        check("busy_after_release", BUSY, 1);
        repeat (10) step();
        check("release_frame", log_slice(0, 10), frame_bits(8'hC3, 1'b0, 1'b0));
        check("release_rinc_count", rinc_count, 1);
        check("release_idle_busy", BUSY, 0);

        // Table-driven single frames.
        for (int i = 0; i < 7; i++) begin
            PAR_EN  = vecs[i].pe;
            PAR_TYP = vecs[i].pt;
            fifo_q.push_back(vecs[i].word);
            sync_fifo();
            clear_logs();
            #1;
            check($sformatf("vec%0d_rinc_latency", i), RINC, 1);
            n = DW + 2 + int'(vecs[i].pe);
            for (int k = 0; k < n; k++) begin
                step();
                if (vecs[i].toggle && k == 4) PAR_TYP = ~PAR_TYP;
            end
            step();
            check($sformatf("vec%0d_line", i), log_slice(0, n), 32'(vecs[i].exp_bits));
            check($sformatf("vec%0d_busy_cycles", i), busy_cycles, n);
            check($sformatf("vec%0d_rinc_count", i), rinc_count, 1);
            check($sformatf("vec%0d_idle_line", i), TX_OUT, 1);
            check($sformatf("vec%0d_idle_busy", i), BUSY, 0);
        end

        // Three words back-to-back.
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
        sync_fifo();
        clear_logs();
        repeat (31) step();
        exp3 = frame_bits(8'h11, 1'b0, 1'b0) | (frame_bits(8'h22, 1'b0, 1'b0) << 10) | (frame_bits(8'h33, 1'b0, 1'b0) << 20);
        check("b2b_line", log_slice(0, 30), exp3);
        check("b2b_rinc_count", rinc_count, 3);
        check("b2b_busy_cycles", busy_cycles, 30);
        check("b2b_idle_busy", BUSY, 0);

        // TX_EN dropped mid-frame with a word still queued.
        TX_EN = 1'b1;
        fifo_q.push_back(8'h44); fifo_q.push_back(8'h55);
        sync_fifo();
        clear_logs();
        repeat (4) step();
        TX_EN = 1'b0;
        repeat (11) step();
        check("txen_line", log_slice(0, 15), frame_bits(8'h44, 1'b0, 1'b0) | 32'h7C00);
        check("txen_rinc_count", rinc_count, 1);
        check("txen_fifo_left", fifo_q.size(), 1);
        check("txen_idle_busy", BUSY, 0);
        TX_EN = 1'b1;
        clear_logs();
        #1;
        check("txen_restore_rinc", RINC, 1);
        repeat (11) step();
        check("txen_restore_line", log_slice(0, 10), frame_bits(8'h55, 1'b0, 1'b0));
        check("txen_restore_rinc_count", rinc_count, 1);

        // Reset at data bit 4.
        fifo_q.push_back(8'h5A);
        sync_fifo();
        clear_logs();
        repeat (6) step();
        check("pre_reset_bit4", TX_OUT, 1);
        check("pre_reset_busy", BUSY, 1);
        #2;
        R_RST = 1'b0;
        #1;
        check("async_reset_line", TX_OUT, 1);
        check("async_reset_busy", BUSY, 0);
        check("async_reset_rinc", RINC, 0);
        repeat (2) @(posedge R_CLK);
        #3;
        R_RST = 1'b1;
        clear_logs();
        repeat (12) step();
        check("post_reset_line", log_slice(0, 12), 32'hFFF);
        check("post_reset_rinc", rinc_count, 0);
        check("post_reset_busy", busy_cycles, 0);

        // Randomized traffic decoded by a line-level receiver model.
        clear_logs();
        pops.delete();
        pushed = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0 && fifo_q.size() < 4) begin
                fifo_q.push_back(DW'($urandom));
                pushed++;
                sync_fifo();
            end
            TX_EN   = ($urandom_range(7) != 0);
            PAR_EN  = 1'($urandom_range(1));
            PAR_TYP = 1'($urandom_range(1));
            step();
        end
        TX_EN = 1'b1;
        guard = 0;
        while ((fifo_q.size() > 0 || BUSY) && guard < 200) begin
            step();
            guard++;
        end
        check("rand_drained", (guard < 200), 1);

        idx = 0; nf = 0; bad_fr = 0; exp_busy = 0;
        while (idx < line_log.size()) begin
            if (line_log[idx] == 1'b1) begin
                idx++;
            end else begin
                if (nf >= pops.size()) begin
                    bad_fr++;
                    break;
                end
                fr  = pops[nf];
                len = DW + 2 + int'(fr.pe);
                if (idx + len > line_log.size()) begin
                    bad_fr++;
                    break;
                end
                check($sformatf("rand_frame%0d", nf), log_slice(idx, len), frame_bits(fr.word, fr.pe, fr.pt));
                exp_busy += len;
                idx += len;
                nf++;
            end
        end
        check("rand_decode_sync", bad_fr, 0);
        check("rand_frames_vs_pushed", nf, pushed);
        check("rand_pops_vs_pushed", pops.size(), pushed);
        check("rand_busy_cycles", busy_cycles, exp_busy);
        check("illegal_pop_count", bad_pop, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
